tft_vram_painter: RTL

//  Write-side engine for the TFT video RAM (VRAM port A, cclk domain). Turns touch samples into

---
 rtl/tft_vram_painter_if.sv | 24 ++
 rtl/tft_vram_painter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tft_vram_painter_if.sv
// tft_vram_painter_if: touch/clear inputs and VRAM port A write bus of the painter.
interface tft_vram_painter_if #(
    parameter int COLOR_W = 9,
    parameter int ADDR_W  = 17
);
    logic               touch_valid;
    logic [11:0]        touch_x;
    logic [11:0]        touch_y;
    logic [COLOR_W-1:0] pen_color;
    logic               clear_req;
    logic               vram_we;
    logic [ADDR_W-1:0]  vram_addr;
    logic [COLOR_W-1:0] vram_din;
    logic               busy;
    logic               clear_done;
    modport master (
        input  touch_valid, touch_x, touch_y, pen_color, clear_req,
        output vram_we, vram_addr, vram_din, busy, clear_done
    );
    modport slave (
        output touch_valid, touch_x, touch_y, pen_color, clear_req,
        input  vram_we, vram_addr, vram_din, busy, clear_done
    );
endinterface

// File: rtl/tft_vram_painter.sv
// tft_vram_painter: paints square brush strokes from touch samples and sweeps a full-screen
// clear into VRAM port A; every output is registered one cycle behind the FSM state.
module tft_vram_painter #(
    parameter int X_RES   = 480,
    parameter int Y_RES   = 272,
    parameter int BRUSH   = 3,
    parameter int COLOR_W = 9,
    parameter int ADDR_W  = 17,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input logic cclk,
    input logic rstb,
    tft_vram_painter_if.master bus
);
    localparam int R  = (BRUSH - 1) / 2;
    localparam int IW = BRUSH > 1 ? $clog2(BRUSH) : 1;
    localparam int PW = 14;
    localparam logic [IW-1:0]     IMAX = IW'(BRUSH - 1);
    localparam logic [ADDR_W-1:0] XR   = ADDR_W'(X_RES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(X_RES * Y_RES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
    state_t state, state_n;

    logic [11:0]        cx, cy, lx, ly, cx_n, cy_n, lx_n, ly_n;
    logic [COLOR_W-1:0] col, lcol, col_n, lcol_n;
    logic [IW-1:0]      ix, iy, ix_n, iy_n;
    logic [ADDR_W-1:0]  caddr, caddr_n;
    logic               lv, lv_n, pend, pend_n, clr_q, fin, fin_n;
    logic               we, we_n, busy, busy_n, done, done_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [COLOR_W-1:0] din, din_n;

    logic [PW-1:0]     sx, sy, px, py;
    logic              x_ok, y_ok, rise, hit;
    logic [ADDR_W-1:0] pix_addr;

    // Brush offsets are kept as unsigned 0..BRUSH-1 so clipping is a plain range check on cx+ix.
    assign sx       = PW'(cx) + PW'(ix);
    assign sy       = PW'(cy) + PW'(iy);
    assign x_ok     = sx >= PW'(R) && sx < PW'(X_RES + R);
    assign y_ok     = sy >= PW'(R) && sy < PW'(Y_RES + R);
    assign px       = x_ok ? sx - PW'(R) : '0;
    assign py       = y_ok ? sy - PW'(R) : '0;
    assign pix_addr = ADDR_W'(py) * XR + ADDR_W'(px);
    assign rise     = bus.clear_req & ~clr_q;
    assign hit      = bus.touch_valid && PW'(bus.touch_x) < PW'(X_RES) && PW'(bus.touch_y) < PW'(Y_RES)
                      && (!lv || bus.touch_x != lx || bus.touch_y != ly || bus.pen_color != lcol);

    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        col_n   = col;
        lx_n    = lx;
        ly_n    = ly;
        lcol_n  = lcol;
        lv_n    = lv;
        ix_n    = ix;
        iy_n    = iy;
        caddr_n = caddr;
        pend_n  = state == CLEAR ? pend : pend | rise;
        fin_n   = 1'b0;
        we_n    = 1'b0;
        addr_n  = addr;
        din_n   = din;
        busy_n  = state != IDLE;
        done_n  = fin;
        case (state)
            IDLE: begin
                if (pend | rise) begin
                    state_n = CLEAR;
                    pend_n  = 1'b0;
                    caddr_n = '0;
                    lv_n    = 1'b0;
                end else if (hit) begin
                    state_n = DRAW;
                    cx_n    = bus.touch_x;
                    cy_n    = bus.touch_y;
                    col_n   = bus.pen_color;
                    lx_n    = bus.touch_x;
                    ly_n    = bus.touch_y;
                    lcol_n  = bus.pen_color;
                    lv_n    = 1'b1;
                    ix_n    = '0;
                    iy_n    = '0;
                end
            end
            DRAW: begin
                we_n    = x_ok && y_ok;
                addr_n  = pix_addr;
                din_n   = col;
                ix_n    = ix == IMAX ? '0 : ix + 1'b1;
                iy_n    = ix == IMAX ? iy + 1'b1 : iy;
                state_n = ix == IMAX && iy == IMAX ? IDLE : DRAW;
            end
            CLEAR: begin
                we_n    = 1'b1;
                addr_n  = caddr;
                din_n   = CLEAR_COLOR;
                caddr_n = caddr + 1'b1;
                fin_n   = caddr == LAST;
                state_n = caddr == LAST ? IDLE : CLEAR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state <= IDLE;
            pend  <= 1'b0;
            lv    <= 1'b0;
            clr_q <= 1'b0;
            fin   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            din   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            lv    <= lv_n;
            clr_q <= bus.clear_req;
            fin   <= fin_n;
            we    <= we_n;
            addr  <= addr_n;
            din   <= din_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge cclk) begin
        cx    <= cx_n;
        cy    <= cy_n;
        col   <= col_n;
        lx    <= lx_n;
        ly    <= ly_n;
        lcol  <= lcol_n;
        ix    <= ix_n;
        iy    <= iy_n;
        caddr <= caddr_n;
    end

    assign bus.vram_we    = we;
    assign bus.vram_addr  = addr;
    assign bus.vram_din   = din;
    assign bus.busy       = busy;
    assign bus.clear_done = done;
endmodule
